// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision post-normalise/round stage.
// Holds the data widths, rounding-mode codes, FSM state encoding,
// special magnitudes and the per-mode round-up decision.
package fpu_pkg;

    localparam int unsigned EXP_W      = 8;
    localparam int unsigned MANT_W     = 23;
    localparam int unsigned FRACT_W    = MANT_W + 5;
    localparam int unsigned IEXP_W     = EXP_W + 1;
    localparam int unsigned SIG_W      = MANT_W + 1;
    localparam int unsigned WORD_W     = 1 + EXP_W + MANT_W;
    localparam int unsigned CARRY_BIT  = FRACT_W - 1;
    localparam int unsigned HIDDEN_BIT = FRACT_W - 2;

    localparam logic [1:0] RM_NEAREST = 2'd0;
    localparam logic [1:0] RM_ZERO    = 2'd1;
    localparam logic [1:0] RM_PINF    = 2'd2;
    localparam logic [1:0] RM_NINF    = 2'd3;

    // Largest biased exponent; reaching it after rounding means overflow.
    localparam logic [IEXP_W-1:0] EXP_MAX = IEXP_W'((1 << EXP_W) - 1);

    // Magnitudes (sign excluded) substituted on overflow.
    localparam logic [WORD_W-2:0] INF_MAG  = (WORD_W-1)'(32'h7F80_0000);
    localparam logic [WORD_W-2:0] MAXF_MAG = (WORD_W-1)'(32'h7F7F_FFFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word_t;

    // Round-up decision for one rounding mode given lsb/guard/round/sticky.
    function automatic logic round_up(input logic [1:0] rmode, input logic sign,
                                      input logic lsb, input logic g,
                                      input logic r, input logic s);
        logic up;
        up = 1'b0;
        case (rmode)
            RM_NEAREST: up = g & (r | s | lsb);
            RM_ZERO:    up = 1'b0;
            RM_PINF:    up = ~sign & (g | r | s);
            RM_NINF:    up = sign & (g | r | s);
            default:    up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Combinational rounding, overflow substitution and IEEE-754 packing.
// Ports:
//   sign_i, exp_i (EXP_W+1), fract_i (normalised), sticky_i, rmode_i : operand after normalise
//   result_o (32), inexact_o, overflow_o, underflow_o                 : packed result and flags
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic [IEXP_W-1:0] exp_i,
    input  logic [FRACT_W-1:0] fract_i,
    input  logic              sticky_i,
    input  logic [1:0]        rmode_i,
    output logic [WORD_W-1:0] result_o,
    output logic              inexact_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    logic               lsb, g, r, s;
    logic               up_mode, up_near, near_carry, ovf, any_lost;
    logic [SIG_W-1:0]   sig;
    logic [SIG_W:0]     sum_mode;
    logic [IEXP_W-1:0]  exp_mode;
    logic [WORD_W-2:0]  ovf_mag;
    fp_word_t           res;

    assign sig      = fract_i[HIDDEN_BIT:3];
    assign lsb      = fract_i[3];
    assign g        = fract_i[2];
    assign r        = fract_i[1];
    assign s        = fract_i[0] | sticky_i;
    assign any_lost = g | r | s;

    assign up_mode  = round_up(rmode_i, sign_i, lsb, g, r, s);
    assign up_near  = round_up(RM_NEAREST, sign_i, lsb, g, r, s);
    assign sum_mode = {1'b0, sig} + (SIG_W+1)'(up_mode);

    // Carry out of the hidden bit bumps the exponent; a denormal that rounds
    // into the hidden bit becomes the smallest normal; otherwise a
    // hidden-less significand packs with exponent 0.
    always_comb begin
        exp_mode = '0;
        if (sum_mode[SIG_W])
            exp_mode = exp_i + IEXP_W'(1);
        else if (sum_mode[SIG_W-1])
            exp_mode = sig[SIG_W-1] ? exp_i : IEXP_W'(1);
    end

    // Overflow is judged on the nearest-rounded magnitude too, so directed
    // modes that round toward zero still flag it and saturate to max finite.
    assign near_carry = up_near & (&sig);
    assign ovf        = (exp_mode >= EXP_MAX) |
                        (near_carry & (exp_i >= (EXP_MAX - IEXP_W'(1))));

    always_comb begin
        ovf_mag = INF_MAG;
        case (rmode_i)
            RM_NEAREST: ovf_mag = INF_MAG;
            RM_ZERO:    ovf_mag = MAXF_MAG;
            RM_PINF:    ovf_mag = sign_i ? MAXF_MAG : INF_MAG;
            RM_NINF:    ovf_mag = sign_i ? INF_MAG : MAXF_MAG;
            default:    ovf_mag = INF_MAG;
        endcase
    end

    always_comb begin
        res         = '0;
        inexact_o   = 1'b0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (fract_i == '0) begin
            res.sign = sign_i;
        end else if (ovf) begin
            res         = fp_word_t'({sign_i, ovf_mag});
            inexact_o   = 1'b1;
            overflow_o  = 1'b1;
        end else begin
            res.sign    = sign_i;
            res.exp     = exp_mode[EXP_W-1:0];
            res.mant    = sum_mode[MANT_W-1:0];
            inexact_o   = any_lost;
            underflow_o = (exp_mode == '0) & any_lost;
        end
    end

    assign result_o = res;

endmodule

// File: rtl/fpu_post_norm_round.sv
// Post-normalise, round and pack stage of the single-precision add/sub datapath.
// Normalises one bit per cycle, rounds in one cycle, holds the result until taken.
// Ports:
//   clk, rst_n                                   : clock, async active-low reset
//   in_valid/in_ready, sign_i, exp_i, fract_i,
//   sticky_i, rmode_i                            : operand handshake and fields
//   out_valid/out_ready, out                     : result handshake and packed word
//   inexact, overflow, underflow                 : exception flags for the held result
module fpu_post_norm_round
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_i,
    input  logic [EXP_W-1:0]   exp_i,
    input  logic [FRACT_W-1:0] fract_i,
    input  logic               sticky_i,
    input  logic [1:0]         rmode_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out,
    output logic               inexact,
    output logic               overflow,
    output logic               underflow
);

    state_e             state_q;
    logic               sign_q;
    logic [IEXP_W-1:0]  exp_q;
    logic [FRACT_W-1:0] fract_q;
    logic               sticky_q;
    logic [1:0]         rmode_q;
    logic [WORD_W-1:0]  out_q;
    logic               inexact_q, overflow_q, underflow_q;
    logic               out_valid_q, in_ready_q;

    logic [WORD_W-1:0]  rp_result;
    logic               rp_inexact, rp_overflow, rp_underflow;

    fpu_round_pack u_round_pack (
        .sign_i      (sign_q),
        .exp_i       (exp_q),
        .fract_i     (fract_q),
        .sticky_i    (sticky_q),
        .rmode_i     (rmode_q),
        .result_o    (rp_result),
        .inexact_o   (rp_inexact),
        .overflow_o  (rp_overflow),
        .underflow_o (rp_underflow)
    );

    // Control FSM with operand/shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            fract_q     <= '0;
            sticky_q    <= 1'b0;
            rmode_q     <= RM_NEAREST;
            out_q       <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q      <= sign_i;
                        exp_q       <= {1'b0, exp_i};
                        fract_q     <= fract_i;
                        sticky_q    <= sticky_i;
                        rmode_q     <= rmode_i;
                        inexact_q   <= 1'b0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= NORM;
                    end
                end
                NORM: begin
                    if (fract_q == '0) begin
                        state_q <= ROUND;
                    end else if (fract_q[CARRY_BIT]) begin
                        fract_q  <= {1'b0, fract_q[FRACT_W-1:1]};
                        sticky_q <= sticky_q | fract_q[0];
                        exp_q    <= exp_q + IEXP_W'(1);
                        state_q  <= ROUND;
                    end else if (!fract_q[HIDDEN_BIT] && (exp_q > IEXP_W'(1))) begin
                        fract_q <= {fract_q[FRACT_W-2:0], 1'b0};
                        exp_q   <= exp_q - IEXP_W'(1);
                    end else begin
                        // Normalised, or stuck at exp 1 as a denormal.
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    out_q       <= rp_result;
                    inexact_q   <= rp_inexact;
                    overflow_q  <= rp_overflow;
                    underflow_q <= rp_underflow;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign inexact   = inexact_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
